// File: rtl/aes256_subbytes_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_subbytes_iter
//  Description : Iterative AES SubBytes / InvSubBytes stage. LANES shared
//                S-boxes process the 16-byte state over NCYC = 16/LANES
//                cycles. The S-box is built from a GF(2^8) inversion and
//                affine transforms, so no lookup ROM is needed. Valid/ready
//                handshake on input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_subbytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         mode_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] state_o,
  output logic         busy_o
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           r_mode;
  logic [CW-1:0]  r_cnt;
  logic [127:0]   r_work;
  logic [127:0]   r_res;
  logic [127:0]   w_res_next;
  logic           w_accept;
  logic           w_last;
  logic [7:0]     w_lane_in  [LANES];
  logic [7:0]     w_lane_out [LANES];

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 without a special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // Forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  assign w_last  = (r_cnt == C_CNT_LAST);
  assign state_o = r_res;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic and handshake outputs decoded from the current state.
  always_comb begin
    w_state_next = r_state;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    busy_o       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        busy_o = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Route the current byte group of the work register onto the lanes.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_lane_in[k] = 8'h00;
      for (int g = 0; g < NCYC; g++) begin
        if (r_cnt == CW'(g)) w_lane_in[k] = r_work[127 - 8*(g*LANES + k) -: 8];
      end
    end
  end

  // One shared S-box per lane; mode selects forward or inverse path.
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_lane_out[k] = r_mode ? gf_inv(aff_inv(w_lane_in[k]))
                                    : aff_fwd(gf_inv(w_lane_in[k]));
    end
  endgenerate

  // Merge the substituted group back into its byte positions.
  always_comb begin
    w_res_next = r_res;
    for (int g = 0; g < NCYC; g++) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_cnt == CW'(g)) w_res_next[127 - 8*(g*LANES + k) -: 8] = w_lane_out[k];
      end
    end
  end

  // Datapath: capture on accept, then step through the groups while busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_work <= 128'h0;
      r_res  <= 128'h0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_work <= state_i;
      r_mode <= mode_i;
      r_cnt  <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt  <= r_cnt + CW'(1);
      r_res  <= w_res_next;
    end
  end

endmodule
`default_nettype wire
